// File: rtl/axi2apb_cmd_arb.sv
// Round-robin AW/AR command arbiter feeding a one-entry output slot in front of the bridge command FIFO.
// Optional write-data credit gating is enabled by defining CMD_ARB_WDATA_GATE_EN.
module axi2apb_cmd_arb #(
  parameter int ADDR_WIDTH   = 32,
  parameter int CREDIT_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [3:0]              awlen_i,
  input  logic [1:0]              awburst_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic [3:0]              arlen_i,
  input  logic [1:0]              arburst_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  input  logic                    wpush_i,
  output logic                    cmd_valid_o,
  output logic [ADDR_WIDTH+6:0]   cmd_data_o,
  input  logic                    cmd_ready_i,
  output logic [CREDIT_WIDTH-1:0] wcredit_o,
  output logic                    credit_ovf_o,
  output logic                    last_grant_o
);

  localparam int CMD_W = ADDR_WIDTH + 7;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t      state, state_nxt;
  logic [CMD_W-1:0] cmd_q, cmd_nxt;
  logic             last_q, last_nxt;
  logic             slot_free;
  logic             aw_elig, ar_elig;
  logic             grant_aw, grant_ar;
  logic             aw_hs, ar_hs;

`ifdef CMD_ARB_WDATA_GATE_EN
  localparam int CMPW = (CREDIT_WIDTH > 5) ? CREDIT_WIDTH : 5;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = '1;

  logic [CREDIT_WIDTH-1:0] credit_q, credit_nxt;
  logic                    ovf_q, ovf_nxt;
  logic [4:0]              aw_beats;
  logic [CMPW-1:0]         credit_ext, beats_ext;

  assign aw_beats   = {1'b0, awlen_i} + 5'd1;
  assign credit_ext = CMPW'(credit_q);
  assign beats_ext  = CMPW'(aw_beats);
  assign aw_elig    = awvalid_i & (credit_ext >= beats_ext);

  // A granted burst always consumes at least one beat, so a simultaneous push cannot overflow.
  always_comb begin
    credit_nxt = credit_q;
    ovf_nxt    = ovf_q;
    if (wpush_i && !aw_hs && (credit_q == CREDIT_MAX)) begin
      ovf_nxt = 1'b1;
    end else begin
      credit_nxt = CREDIT_WIDTH'(credit_ext + CMPW'(wpush_i) - (aw_hs ? beats_ext : '0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      credit_q <= credit_nxt;
      ovf_q    <= ovf_nxt;
    end
  end

  assign wcredit_o    = credit_q;
  assign credit_ovf_o = ovf_q;
`else
  logic unused_wpush;

  assign unused_wpush = wpush_i;
  assign aw_elig      = awvalid_i;
  assign wcredit_o    = '0;
  assign credit_ovf_o = 1'b0;
`endif

  assign ar_elig   = arvalid_i;
  assign slot_free = (state == EMPTY) | cmd_ready_i;

  // On a tie the requester that did not win last time goes first.
  assign grant_aw = aw_elig & (~ar_elig | ~last_q);
  assign grant_ar = ar_elig & (~aw_elig |  last_q);

  assign aw_hs = rst_n & slot_free & grant_aw;
  assign ar_hs = rst_n & slot_free & grant_ar;

  assign awready_o = aw_hs;
  assign arready_o = ar_hs;

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_q;
    last_nxt  = last_q;
    if (aw_hs) begin
      state_nxt = FULL;
      cmd_nxt   = {1'b1, awburst_i, awlen_i, awaddr_i};
      last_nxt  = 1'b1;
    end else if (ar_hs) begin
      state_nxt = FULL;
      cmd_nxt   = {1'b0, arburst_i, arlen_i, araddr_i};
      last_nxt  = 1'b0;
    end else if ((state == FULL) && cmd_ready_i) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= EMPTY;
      cmd_q  <= '0;
      last_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cmd_q  <= cmd_nxt;
      last_q <= last_nxt;
    end
  end

  assign cmd_valid_o  = (state == FULL);
  assign cmd_data_o   = cmd_q;
  assign last_grant_o = last_q;

endmodule

// File: tb/tb_axi2apb_cmd_arb.sv
// Directed bench for axi2apb_cmd_arb: expected commands are queued by the stimulus and checked on every pop.
module tb_axi2apb_cmd_arb;
  localparam int AW = 32;
  localparam int CW = 5;
  localparam int DW = AW + 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] awaddr, araddr;
  logic [3:0]    awlen, arlen;
  logic [1:0]    awburst, arburst;
  logic          awvalid, arvalid, awready, arready;
  logic          wpush;
  logic          cmd_valid, cmd_ready;
  logic [DW-1:0] cmd_data;
  logic [CW-1:0] wcredit;
  logic          credit_ovf, last_grant;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  axi2apb_cmd_arb #(.ADDR_WIDTH(AW), .CREDIT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr_i(awaddr), .awlen_i(awlen), .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready),
    .araddr_i(araddr), .arlen_i(arlen), .arburst_i(arburst), .arvalid_i(arvalid), .arready_o(arready),
    .wpush_i(wpush),
    .cmd_valid_o(cmd_valid), .cmd_data_o(cmd_data), .cmd_ready_i(cmd_ready),
    .wcredit_o(wcredit), .credit_ovf_o(credit_ovf), .last_grant_o(last_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic w, input logic [1:0] b, input logic [3:0] l,
                                       input logic [AW-1:0] a);
    return {w, b, l, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted command must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop: got 0x%0h expected no command", cmd_data);
      end else begin
        chk("pop_data", 64'(cmd_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; awaddr = '0; araddr = '0; awlen = '0; arlen = '0;
    awburst = '0; arburst = '0; awvalid = 1'b1; arvalid = 1'b1; wpush = 1'b0; cmd_ready = 1'b1;

    // Reset held for two cycles with both requests up.
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_awready", 64'(awready), 64'd0);
      chk("rst_arready", 64'(arready), 64'd0);
      @(posedge clk);
    end
    #1;
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_cmd_data", 64'(cmd_data), 64'd0);
    chk("rst_wcredit", 64'(wcredit), 64'd0);
    chk("rst_ovf", 64'(credit_ovf), 64'd0);
    chk("rst_last_grant", 64'(last_grant), 64'd0);
    chk("rst_readys", 64'({awready, arready}), 64'd0);
    awvalid = 1'b0; arvalid = 1'b0; rst_n = 1'b1;
    step();

    // Single read.
    arvalid = 1'b1; araddr = 32'h0001_0004; arlen = 4'd0; arburst = 2'b01;
    #1;
    chk("rd_arready", 64'(arready), 64'd1);
    chk("rd_awready", 64'(awready), 64'd0);
    exp_q.push_back(mk(1'b0, 2'b01, 4'd0, 32'h0001_0004));
    step();
    arvalid = 1'b0;
    chk("rd_cmd_valid", 64'(cmd_valid), 64'd1);
    chk("rd_cmd_data", 64'(cmd_data), 64'(mk(1'b0, 2'b01, 4'd0, 32'h0001_0004)));
    chk("rd_last_grant", 64'(last_grant), 64'd0);
    step();
    chk("rd_slot_empty", 64'(cmd_valid), 64'd0);

`ifdef CMD_ARB_WDATA_GATE_EN
    for (int i = 0; i < 4; i++) begin
      wpush = 1'b1;
      step();
    end
    wpush = 1'b0;
    chk("rr_preload_credit", 64'(wcredit), 64'd4);
`endif

    // Round-robin with both requesters continuously valid; first tie goes to AW.
    awvalid = 1'b1; arvalid = 1'b1; awlen = 4'd1; awburst = 2'b01; arlen = 4'd2; arburst = 2'b10;
    for (int i = 0; i < 4; i++) begin
      logic exp_aw;
      exp_aw = (i % 2 == 0);
      awaddr = 32'h0000_1000 + 32'(i * 4);
      araddr = 32'h0000_2000 + 32'(i * 4);
      #1;
      chk("rr_awready", 64'(awready), 64'(exp_aw));
      chk("rr_arready", 64'(arready), 64'(!exp_aw));
      if (exp_aw) exp_q.push_back(mk(1'b1, 2'b01, 4'd1, 32'h0000_1000 + 32'(i * 4)));
      else        exp_q.push_back(mk(1'b0, 2'b10, 4'd2, 32'h0000_2000 + 32'(i * 4)));
      step();
      chk("rr_last_grant", 64'(last_grant), 64'(exp_aw));
    end
    awvalid = 1'b0; arvalid = 1'b0;
`ifdef CMD_ARB_WDATA_GATE_EN
    chk("rr_credit_spent", 64'(wcredit), 64'd0);
`endif
    step();

    // Backpressure: slot held for three cycles, then pop and reload together.
    arvalid = 1'b1; araddr = 32'h0000_4000; arlen = 4'd5; arburst = 2'b00;
    #1;
    chk("bp_load_arready", 64'(arready), 64'd1);
    exp_q.push_back(mk(1'b0, 2'b00, 4'd5, 32'h0000_4000));
    step();
    cmd_ready = 1'b0; awvalid = 1'b1; awlen = 4'd0; araddr = 32'h0000_5000; arlen = 4'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_readys", 64'({awready, arready}), 64'd0);
      chk("bp_cmd_valid", 64'(cmd_valid), 64'd1);
      chk("bp_cmd_data", 64'(cmd_data), 64'(mk(1'b0, 2'b00, 4'd5, 32'h0000_4000)));
      step();
    end
    cmd_ready = 1'b1; awvalid = 1'b0;
    #1;
    chk("bp_reload_arready", 64'(arready), 64'd1);
    exp_q.push_back(mk(1'b0, 2'b00, 4'd7, 32'h0000_5000));
    step();
    arvalid = 1'b0;
    chk("bp_reload_data", 64'(cmd_data), 64'(mk(1'b0, 2'b00, 4'd7, 32'h0000_5000)));
    step();

    // Write gating on accumulated data beats.
    awvalid = 1'b1; awlen = 4'd3; awburst = 2'b01; awaddr = 32'h0000_3000;
`ifdef CMD_ARB_WDATA_GATE_EN
    for (int i = 0; i < 4; i++) begin
      wpush = 1'b1;
      #1;
      chk("gate_wait_awready", 64'(awready), 64'd0);
      step();
      chk("gate_credit", 64'(wcredit), 64'(i + 1));
    end
    wpush = 1'b0;
    #1;
    chk("gate_awready", 64'(awready), 64'd1);
    exp_q.push_back(mk(1'b1, 2'b01, 4'd3, 32'h0000_3000));
    step();
    awvalid = 1'b0;
    chk("gate_credit_after", 64'(wcredit), 64'd0);
`else
    wpush = 1'b1;
    #1;
    chk("nogate_awready", 64'(awready), 64'd1);
    exp_q.push_back(mk(1'b1, 2'b01, 4'd3, 32'h0000_3000));
    step();
    awvalid = 1'b0; wpush = 1'b0;
    chk("nogate_credit", 64'(wcredit), 64'd0);
`endif
    chk("gate_last_grant", 64'(last_grant), 64'd1);
    step();

    // Credit saturation and sticky overflow.
    for (int i = 0; i < 32; i++) begin
      wpush = 1'b1;
      step();
`ifdef CMD_ARB_WDATA_GATE_EN
      if (i < 31) begin
        chk("sat_credit", 64'(wcredit), 64'(i + 1));
        chk("sat_ovf_clear", 64'(credit_ovf), 64'd0);
      end
`endif
    end
    wpush = 1'b0;
    step();
    step();
    step();
`ifdef CMD_ARB_WDATA_GATE_EN
    chk("sat_credit_max", 64'(wcredit), 64'd31);
    chk("sat_ovf_sticky", 64'(credit_ovf), 64'd1);
`else
    chk("nogate_sat_credit", 64'(wcredit), 64'd0);
    chk("nogate_sat_ovf", 64'(credit_ovf), 64'd0);
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("final_rst_ovf", 64'(credit_ovf), 64'd0);
    chk("final_rst_credit", 64'(wcredit), 64'd0);
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
